// File: rtl/multadd_pipe.sv
// rtl/multadd_pipe.sv - flow-controlled two-lane multiply-add pipe with tag, in-flight count
// Optional MULTADD_CARRY_EN: per-op carry bit selects full 2W-bit add instead of lane-wise add.
module multadd_pipe #(
   parameter int W        = 64,
   parameter int MULT_LAT = 18,
   parameter int ADD_LAT  = 6,
   parameter int TAG_W    = 8,
   localparam int CNT_W   = $clog2(MULT_LAT + ADD_LAT + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       a,
   input  logic [W-1:0]       b,
   input  logic [2*W-1:0]     c,
   input  logic [TAG_W-1:0]   tag,
   input  logic               carry,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*W-1:0]     p,
   output logic [TAG_W-1:0]   out_tag,
   output logic [CNT_W-1:0]   inflight
);

   logic adv;
   logic take;
   logic [2*W-1:0] prod_in;

   logic             m_vld  [MULT_LAT];
   logic [2*W-1:0]   m_prod [MULT_LAT];
   logic [2*W-1:0]   m_c    [MULT_LAT];
   logic [TAG_W-1:0] m_tag  [MULT_LAT];

   logic             s_vld [ADD_LAT];
   logic [2*W-1:0]   s_sum [ADD_LAT];
   logic [TAG_W-1:0] s_tag [ADD_LAT];

   logic [2*W-1:0] lane_sum;
   logic [2*W-1:0] sum;
   logic           last_in_vld;

   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;
   assign take     = in_valid & adv;

   assign prod_in = {{W{1'b0}}, a} * {{W{1'b0}}, b};

   // The two lanes wrap independently; no carry crosses from lo to hi here.
   assign lane_sum = {m_prod[MULT_LAT-1][2*W-1:W] + m_c[MULT_LAT-1][2*W-1:W],
                      m_prod[MULT_LAT-1][W-1:0]   + m_c[MULT_LAT-1][W-1:0]};

`ifdef MULTADD_CARRY_EN
   logic m_cy [MULT_LAT];
   logic [2*W-1:0] full_sum;

   assign full_sum = m_prod[MULT_LAT-1] + m_c[MULT_LAT-1];
   assign sum      = m_cy[MULT_LAT-1] ? full_sum : lane_sum;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < MULT_LAT; i++) m_cy[i] <= 1'b0;
      end else if (adv) begin
         m_cy[0] <= carry;
         for (int i = 1; i < MULT_LAT; i++) m_cy[i] <= m_cy[i-1];
      end
   end
`else
   logic unused_carry;

   assign unused_carry = carry;
   assign sum          = lane_sum;
`endif

   generate
      if (ADD_LAT == 1) begin : g_last_from_mult
         assign last_in_vld = m_vld[MULT_LAT-1];
      end else begin : g_last_from_add
         assign last_in_vld = s_vld[ADD_LAT-2];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < MULT_LAT; i++) begin
            m_vld[i]  <= 1'b0;
            m_prod[i] <= '0;
            m_c[i]    <= '0;
            m_tag[i]  <= '0;
         end
         for (int i = 0; i < ADD_LAT; i++) begin
            s_vld[i] <= 1'b0;
            s_sum[i] <= '0;
            s_tag[i] <= '0;
         end
      end else if (adv) begin
         m_vld[0]  <= in_valid;
         m_prod[0] <= prod_in;
         m_c[0]    <= c;
         m_tag[0]  <= tag;
         for (int i = 1; i < MULT_LAT; i++) begin
            m_vld[i]  <= m_vld[i-1];
            m_prod[i] <= m_prod[i-1];
            m_c[i]    <= m_c[i-1];
            m_tag[i]  <= m_tag[i-1];
         end
         s_vld[0] <= m_vld[MULT_LAT-1];
         s_sum[0] <= sum;
         s_tag[0] <= m_tag[MULT_LAT-1];
         for (int i = 1; i < ADD_LAT; i++) begin
            s_vld[i] <= s_vld[i-1];
            s_sum[i] <= s_sum[i-1];
            s_tag[i] <= s_tag[i-1];
         end
         // Output stage never shows stale data while idle.
         if (!last_in_vld) begin
            s_sum[ADD_LAT-1] <= '0;
            s_tag[ADD_LAT-1] <= '0;
         end
      end
   end

   assign out_valid = s_vld[ADD_LAT-1];
   assign p         = s_sum[ADD_LAT-1];
   assign out_tag   = s_tag[ADD_LAT-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight <= '0;
      end else begin
         case ({take, out_valid & out_ready})
            2'b10:   inflight <= inflight + CNT_W'(1);
            2'b01:   inflight <= inflight - CNT_W'(1);
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_multadd_pipe.sv
// tb/tb_multadd_pipe.sv - directed and randomized bench for multadd_pipe with a queue reference model
module tb_multadd_pipe;
   localparam int W = 64, ML = 18, AL = 6, TW = 8, CW = 5, LAT = ML + AL;
   localparam int RW = 2*W + TW;

   logic clk = 0, rst_n = 0, in_valid = 0, carry = 0, out_ready = 1;
   logic in_ready, out_valid;
   logic [W-1:0] a = '0, b = '0;
   logic [2*W-1:0] c = '0, p;
   logic [TW-1:0] tag = '0, out_tag;
   logic [CW-1:0] inflight;

   multadd_pipe #(.W(W), .MULT_LAT(ML), .ADD_LAT(AL), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .tag(tag), .carry(carry),
      .out_valid(out_valid), .out_ready(out_ready), .p(p), .out_tag(out_tag),
      .inflight(inflight));

   always #5 clk = ~clk;

   int tests = 0, fails = 0, cyc = 0;
   logic [RW-1:0] exp_q[$];
   int exp_infl = 0;
   bit acc_flag = 0, held = 0, rand_rdy = 0;
   logic [2*W-1:0] held_p, last_p;
   logic [TW-1:0] held_tag;
   int acc_first, out_first, out_last, out_n, max_infl;
   logic [W-1:0] ones = '1;

   task automatic check(input string name, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic [2*W-1:0] mc, input logic mcy);
      logic [2*W-1:0] prod;
      logic [W-1:0] lo, hi;
      prod = (2*W)'(ma) * (2*W)'(mb);
      lo = prod[W-1:0] + mc[W-1:0];
      hi = prod[2*W-1:W] + mc[2*W-1:W];
`ifdef MULTADD_CARRY_EN
      if (mcy) return prod + mc;
`endif
      return {hi, lo};
   endfunction

   task automatic clear_stats();
      acc_first = -1; out_first = -1; out_last = -1; out_n = 0; max_infl = 0;
   endtask

   task automatic step();
      @(negedge clk);
      acc_flag = in_valid && in_ready && rst_n;
      if (!rst_n) begin
         exp_q.delete();
         exp_infl = 0;
         held = 0;
      end else begin
         check("in_ready", in_ready, out_ready || !out_valid);
         if (held) begin
            check("hold_valid", out_valid, 1);
            check("hold_p", p, held_p);
            check("hold_tag", out_tag, held_tag);
         end
         if (!out_valid) begin
            check("idle_p", p, 0);
            check("idle_tag", out_tag, 0);
         end
         if (acc_flag) begin
            exp_q.push_back({model(a, b, c, carry), tag});
            exp_infl++;
            if (acc_first < 0) acc_first = cyc;
         end
         if (out_valid) begin
            if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
            else if (out_ready) begin
               check("result", {p, out_tag}, exp_q.pop_front());
               exp_infl--;
               last_p = p;
               if (out_first < 0) out_first = cyc;
               out_last = cyc;
               out_n++;
            end
         end
         held = out_valid && !out_ready;
         held_p = p;
         held_tag = out_tag;
      end
      @(posedge clk);
      #1;
      cyc++;
      check("inflight", inflight, exp_infl);
      if (int'(inflight) > max_infl) max_infl = int'(inflight);
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2*W-1:0] ic,
                       input logic [TW-1:0] it, input logic icy);
      bit ok;
      ok = 0;
      a = ia; b = ib; c = ic; tag = it; carry = icy; in_valid = 1;
      for (int k = 0; k < 200; k++) begin
         step();
         if (acc_flag) begin ok = 1; break; end
      end
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      in_valid = 0;
      for (int k = 0; k < 400; k++) begin
         if (exp_q.size() == 0 && !out_valid) begin ok = 1; break; end
         step();
      end
      if (!ok) check("drain_timeout", 0, 1);
   endtask

   function automatic logic [W-1:0] r64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      bit seen;
      clear_stats();
      step(); step();
      rst_n = 1;
      check("rst_out_valid", out_valid, 0);
      check("rst_p", p, 0);
      check("rst_tag", out_tag, 0);
      check("rst_inflight", inflight, 0);
      out_ready = 0;
      #1;
      check("rst_in_ready", in_ready, 1);
      out_ready = 1;

      // single operation and latency
      clear_stats();
      send(64'd2, 64'd3, {64'd5, 64'd7}, 8'h11, 0);
      drain();
      check("t1_latency", out_first - acc_first, LAT);
      check("t1_p", last_p, {64'd5, 64'd13});

      // lane wrap, lane-wise and carry-mode
      send(ones, ones, {64'd1, ones}, 8'h22, 0);
      drain();
      check("wrap_lane", last_p, {ones, 64'd0});
      send(ones, ones, {64'd1, ones}, 8'h23, 1);
      drain();
`ifdef MULTADD_CARRY_EN
      check("wrap_carry", last_p, {64'd0, 64'd0});
`else
      check("wrap_carry", last_p, {ones, 64'd0});
`endif

      // back-to-back stream
      clear_stats();
      for (int i = 0; i < 30; i++) send(r64(), r64(), {r64(), r64()}, TW'(i), 0);
      drain();
      check("stream_count", out_n, 30);
      check("stream_contig", out_last - out_first, 29);
      check("stream_latency", out_first - acc_first, LAT);
      check("stream_max_inflight", max_infl, LAT);

      // backpressure with an offer held during the stall
      clear_stats();
      for (int i = 0; i < 5; i++) send(r64(), r64(), {r64(), r64()}, TW'(8'h40 + i), 0);
      in_valid = 0;
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         if (out_valid) begin seen = 1; break; end
         step();
      end
      check("bp_first_out", seen, 1);
      out_ready = 0;
      a = r64(); b = r64(); c = {r64(), r64()}; tag = 8'h45; carry = 0; in_valid = 1;
      repeat (10) step();
      check("bp_pending", exp_q.size(), 5);
      check("bp_no_out", out_n, 0);
      out_ready = 1;
      send(a, b, c, tag, 0);
      drain();
      check("bp_count", out_n, 6);

      // randomized traffic with random backpressure
      rand_rdy = 1;
      for (int i = 0; i < 40; i++) begin
         send(r64(), r64(), {r64(), r64()}, TW'($urandom), 1'($urandom));
         if ($urandom_range(0, 2) == 0) begin in_valid = 0; step(); end
      end
      drain();
      rand_rdy = 0;
      out_ready = 1;

      // reset with operations in flight
      for (int i = 0; i < 10; i++) send(r64(), r64(), {r64(), r64()}, TW'(i), 0);
      in_valid = 0;
      rst_n = 0;
      step();
      rst_n = 1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_inflight", inflight, 0);
      clear_stats();
      repeat (30) step();
      check("midrst_quiet", out_n, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
